// File: rtl/mdu_ctrl_if.sv
// Issue/result bundle between the E-stage pipeline and the multiply/divide unit.
// The pipeline (master) drives the operation; the MDU (slave) returns status and HI/LO.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic        stall_req;
  logic [31:0] read_data;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val, d_is_md,
    input  busy, stall_req, read_data, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, d_is_md,
    output busy, stall_req, read_data, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle HI/LO controller: computes MULT/DIV results at issue, holds them
// pending for a fixed busy window, then commits to HI/LO; also MTHI/MTLO/MFHI/MFLO.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset_n,
  mdu_ctrl_if.slave mdu
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 4;

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q;
  logic [DW-1:0]     hi_q, lo_q;
  logic [DW-1:0]     pend_hi, pend_lo;

  logic [2*DW-1:0]   prod_s, prod_u;
  logic              div_signed, a_neg, b_neg, div_zero;
  logic [DW-1:0]     a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  logic [DW-1:0]     res_hi, res_lo;

  // Operand arithmetic, evaluated in the issue cycle.
  always_comb begin
    prod_s     = {{DW{mdu.rs_val[DW-1]}}, mdu.rs_val} * {{DW{mdu.rt_val[DW-1]}}, mdu.rt_val};
    prod_u     = {{DW{1'b0}}, mdu.rs_val} * {{DW{1'b0}}, mdu.rt_val};

    // Magnitude divide then fix signs: truncation toward zero, remainder follows dividend.
    // 0x80000000 / -1 naturally yields 0x80000000 rem 0 on this path.
    div_signed = (mdu.md_op == OP_DIV);
    a_neg      = div_signed & mdu.rs_val[DW-1];
    b_neg      = div_signed & mdu.rt_val[DW-1];
    a_mag      = a_neg ? -mdu.rs_val : mdu.rs_val;
    b_mag      = b_neg ? -mdu.rt_val : mdu.rt_val;
    div_zero   = (mdu.rt_val == '0);
    b_safe     = div_zero ? DW'(1) : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quo        = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem        = a_neg ? -r_mag : r_mag;

    res_hi = hi_q;
    res_lo = lo_q;
    case (mdu.md_op)
      OP_MULT:  begin res_hi = prod_s[2*DW-1:DW]; res_lo = prod_s[DW-1:0]; end
      OP_MULTU: begin res_hi = prod_u[2*DW-1:DW]; res_lo = prod_u[DW-1:0]; end
      OP_DIV, OP_DIVU: begin
        // A zero divisor re-commits the current HI/LO, leaving them unchanged.
        if (!div_zero) begin
          res_hi = rem;
          res_lo = quo;
        end
      end
      default: ;
    endcase
  end

  // State, counter, pending result and architectural HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (state == IDLE) begin
      if (mdu.start) begin
        case (mdu.md_op)
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            cnt     <= mdu.md_op[1] ? DIV_N : MULT_N;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
          OP_MTHI: hi_q <= mdu.rs_val;
          OP_MTLO: lo_q <= mdu.rs_val;
          default: ;
        endcase
      end
    end else begin
      // Start is ignored here; cnt saturates at zero on the final commit.
      if (cnt <= CNT_W'(1)) begin
        hi_q   <= pend_hi;
        lo_q   <= pend_lo;
        cnt    <= '0;
        busy_q <= 1'b0;
        state  <= IDLE;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign mdu.busy      = busy_q;
  assign mdu.hi        = hi_q;
  assign mdu.lo        = lo_q;
  assign mdu.stall_req = mdu.d_is_md & (mdu.start | busy_q);
  assign mdu.read_data = (mdu.md_op == OP_MFHI) ? hi_q :
                         (mdu.md_op == OP_MFLO) ? lo_q : '0;

  // The stall logic should make an issue during a busy window impossible.
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (!reset_n)
                                          !(mdu.start && busy_q));

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset; asynchronous, active-low.
REQ-005 start  in  1  E-stage issue strobe, one cycle per MDU instruction.
REQ-006 md_op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
REQ-007 rs_val  in  32  forwarded GPR[rs], operand A or MTHI/MTLO source.
REQ-008 rt_val  in  32  forwarded GPR[rt], operand B.
REQ-009 d_is_md  in  1  D-stage instruction is any MDU op (md_op 0-7).
REQ-010 busy  out  1  multiply/divide in progress.
REQ-011 stall_req  out  1  freeze D stage, insert bubble into E.
REQ-012 read_data  out  32  MFHI/MFLO result to E-stage result mux.
REQ-013 hi  out  32  architectural HI register.
REQ-014 lo  out  32  architectural LO register.

Function
REQ-015 The block SHALL use two states: IDLE (cnt==0) and RUN (cnt!=0); cnt is 4 bits wide; busy = (cnt != 0), registered.
REQ-016 If start is high in IDLE with md_op 0-3, the block SHALL latch the 64-bit result in pending registers and load cnt with MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3) at the same edge.
REQ-017 In RUN, cnt SHALL decrement by 1 per cycle; at the edge where cnt goes 1->0, the block SHALL copy pending_hi to hi and pending_lo to lo.
REQ-018 Timing: start sampled at edge k -> busy=1 for cycles k+1 through k+N -> new hi/lo and busy=0 visible from cycle k+N+1.
REQ-019 MULT SHALL compute the signed 64-bit product of rs_val*rt_val, and MULTU the unsigned product; hi receives bits 63:32 and lo receives bits 31:0.
REQ-020 DIV/DIVU SHALL write the quotient to lo and the remainder to hi; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0x00000000.
REQ-022 A divisor of 0 SHALL still run DIV_CYCLES and SHALL leave hi and lo unchanged.
REQ-023 MTHI/MTLO with start in IDLE SHALL write rs_val to hi/lo at that edge, with no busy cycles.
REQ-024 read_data SHALL be combinational: hi when md_op==6, lo when md_op==7, otherwise 0; it reflects the registered hi/lo.
REQ-025 stall_req SHALL equal d_is_md & (start | busy), combinationally.
REQ-026 The block SHALL ignore start while busy=1: no state change, pending result preserved. This case is unreachable under REQ-025 and is flagged by an assertion in simulation.
REQ-027 Widths: cnt saturates at 0 and never wraps; MULT_CYCLES and DIV_CYCLES SHALL be in the range 1-15.

Reset
REQ-028 When reset_n is low, the block SHALL immediately force hi=0, lo=0, cnt=0, busy=0, pending_hi=0 and pending_lo=0, regardless of clk.
REQ-029 A reset asserted during RUN SHALL abort the operation; the pending result SHALL be discarded and SHALL NOT be committed after reset_n rises.
REQ-030 After reset_n is released, the first rising edge SHALL process start normally.

Verification
REQ-031 MULT: rs=0xFFFFFFFE (-2), rt=3, start at edge 0 -> busy cycles 1-5 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA from cycle 6.
REQ-032 MULTU: rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-033 DIV: rs=-7 (0xFFFFFFF9), rt=2 -> 10 busy cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF. Repeat with rt=0 -> hi/lo unchanged.
REQ-034 Hazard: DIV issued while d_is_md=1 (MFLO) -> stall_req=1 from the issue cycle through the last busy cycle, drops when busy=0; read_data equals the new lo.
REQ-035 Reset mid-op: MULT started, reset_n pulsed low at busy cycle 3 -> busy=0, hi=lo=0 immediately, no later commit.
REQ-036 MTHI rs=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy stays 0; MFHI then gives read_data=0x12345678.
